// File: rtl/register_controller.sv
// register_controller: sequences CLEAR/LOAD/SHL/SHR requests into one-cycle
// commands for an external register that samples on negedge. It also keeps a
// shadow copy of what that register should contain.
module register_controller #(
  parameter int WIDTH  = 4,
  parameter int CWIDTH = 3
) (
  input  logic              clockController,
  input  logic              resetController,
  input  logic              startController,
  input  logic [1:0]        opController,
  input  logic [WIDTH-1:0]  dataController,
  input  logic [CWIDTH-1:0] countController,
  output logic [2:0]        comandController,
  output logic [WIDTH-1:0]  dataOutController,
  output logic              busyController,
  output logic              doneController,
  output logic [WIDTH-1:0]  shadowController
);

  typedef enum logic [1:0] {INIT, IDLE, ISSUE, DONE} state_t;

  localparam logic [2:0] CMD_HOLD  = 3'b000;
  localparam logic [2:0] CMD_RESET = 3'b001;
  localparam logic [2:0] CMD_LOAD  = 3'b010;
  localparam logic [2:0] CMD_SHL   = 3'b011;
  localparam logic [2:0] CMD_SHR   = 3'b100;

  state_t              state, state_next;
  logic [CWIDTH-1:0]   rem, rem_next;     // commands still to issue after the current one
  logic                quiet, quiet_next; // current operation is the post-reset RESET: no done pulse
  logic [2:0]          cmd, cmd_next;
  logic [WIDTH-1:0]    dout, dout_next;
  logic                busy, busy_next;
  logic                done, done_next;
  logic [WIDTH-1:0]    shadow, shadow_next;

  // Register content after it has executed one command cycle.
  function automatic logic [WIDTH-1:0] predict(input logic [2:0] c,
                                               input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] load);
    case (c)
      CMD_RESET: predict = '0;
      CMD_LOAD:  predict = load;
      CMD_SHL:   predict = {cur[WIDTH-2:0], 1'b0};
      CMD_SHR:   predict = {1'b0, cur[WIDTH-1:1]};
      default:   predict = cur;
    endcase
  endfunction

  // State and registered outputs; everything clears asynchronously.
  always_ff @(posedge clockController or negedge resetController) begin
    if (!resetController) begin
      state  <= INIT;
      rem    <= '0;
      quiet  <= 1'b0;
      cmd    <= CMD_HOLD;
      dout   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      shadow <= '0;
    end else begin
      state  <= state_next;
      rem    <= rem_next;
      quiet  <= quiet_next;
      cmd    <= cmd_next;
      dout   <= dout_next;
      busy   <= busy_next;
      done   <= done_next;
      shadow <= shadow_next;
    end
  end

  // Next-state and next-output decode; the command issued this cycle is
  // folded into the shadow at the edge that ends it.
  always_comb begin
    state_next  = state;
    rem_next    = rem;
    quiet_next  = quiet;
    cmd_next    = CMD_HOLD;
    dout_next   = dout;
    busy_next   = 1'b0;
    done_next   = 1'b0;
    shadow_next = predict(cmd, shadow, dout);
    case (state)
      INIT: begin
        cmd_next   = CMD_RESET;
        busy_next  = 1'b1;
        rem_next   = '0;
        quiet_next = 1'b1;
        state_next = ISSUE;
      end
      ISSUE: begin
        if (rem != '0) begin
          cmd_next  = cmd;
          rem_next  = rem - CWIDTH'(1);
          busy_next = 1'b1;
        end else begin
          done_next  = !quiet;
          state_next = quiet ? IDLE : DONE;
        end
      end
      IDLE, DONE: begin
        state_next = IDLE;
        if (startController) begin
          busy_next  = 1'b1;
          quiet_next = 1'b0;
          rem_next   = '0;
          state_next = ISSUE;
          case (opController)
            2'b00: cmd_next = CMD_RESET;
            2'b01: begin
              cmd_next  = CMD_LOAD;
              dout_next = dataController;
            end
            default: begin
              // A zero count still spends one busy cycle, issuing HOLD.
              if (countController != '0) begin
                cmd_next = (opController == 2'b10) ? CMD_SHL : CMD_SHR;
                rem_next = countController - CWIDTH'(1);
              end
            end
          endcase
        end
      end
      default: state_next = INIT;
    endcase
  end

  assign comandController  = cmd;
  assign dataOutController = dout;
  assign busyController    = busy;
  assign doneController    = done;
  assign shadowController  = shadow;

endmodule

// File: doc/register_controller.md
REGISTER_CONTROLLER -- requirements
Module: register_controller

Interface
REQ-001 Parameter WIDTH, default 4: data width, equal to the driven register's width.
REQ-002 Parameter CWIDTH, default 3: shift-count width.
REQ-003 The module SHALL have port clockController, input, 1 bit: single clock; all state updates on posedge.
REQ-004 The module SHALL have port resetController, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The module SHALL have port startController, input, 1 bit: request strobe, sampled on posedge.
REQ-006 The module SHALL have port opController, input, 2 bits: 00 CLEAR, 01 LOAD, 10 SHL, 11 SHR.
REQ-007 The module SHALL have port dataController, input, WIDTH bits: LOAD operand.
REQ-008 The module SHALL have port countController, input, CWIDTH bits: shift count for SHL/SHR.
REQ-009 The module SHALL have port comandController, output, 3 bits: command to register; HOLD 000, RESET 001, LOAD 010, ShiftLeft 011, ShiftRight 100.
REQ-010 The module SHALL have port dataOutController, output, WIDTH bits: value for the register's data input.
REQ-011 The module SHALL have port busyController, output, 1 bit: operation in progress; start ignored.
REQ-012 The module SHALL have port doneController, output, 1 bit: one-cycle completion pulse.
REQ-013 The module SHALL have port shadowController, output, WIDTH bits: predicted register content.

Function
REQ-014 All outputs SHALL be registered and change only on posedge, so each command is stable across the register's sampling negedge.
REQ-015 The state machine SHALL have states INIT, IDLE, ISSUE, DONE.
REQ-016 INIT: on the first posedge after reset release, drive RESET for exactly one cycle with busy=1, then enter IDLE; shadow=0; no done pulse.
REQ-017 A start SHALL be accepted only when busy=0 (IDLE or DONE); op, data and count SHALL be latched on the accepting edge; start with busy=1 SHALL be ignored without effect.
REQ-018 CLEAR SHALL issue RESET for one cycle; LOAD SHALL issue LOAD for one cycle with dataOutController=latched data.
REQ-019 SHL/SHR with count N>0 SHALL issue exactly N consecutive ShiftLeft/ShiftRight cycles, one command per cycle, with no HOLD gaps.
REQ-020 The first command SHALL be driven from the accepting posedge; busy SHALL be high from that edge through the last command cycle.
REQ-021 SHL/SHR with count 0 SHALL issue no command, and SHALL still raise busy for one cycle followed by a done pulse.
REQ-022 After the last command cycle the module SHALL drive HOLD, set busy=0, and pulse done for exactly one cycle (DONE state).
REQ-023 A start accepted in DONE SHALL begin the next operation on that edge: back-to-back operations SHALL have no idle cycle, and done SHALL still be high in that cycle.
REQ-024 comandController SHALL be HOLD whenever no command is issued.
REQ-025 Shadow SHALL update at the posedge ending each command cycle: RESET->0, LOAD->data, ShiftLeft->shadow<<1, ShiftRight->shadow>>1, all zero-fill.
REQ-026 Count >= WIDTH SHALL still issue N commands, leaving shadow = 0.
REQ-027 dataOutController SHALL hold the last latched LOAD operand and be 0 after reset.

Reset
REQ-028 Asserting resetController SHALL force immediately: comand=HOLD, dataOut=0, busy=0, done=0, shadow=0, state=INIT.
REQ-029 Reset during ISSUE SHALL abort the operation without a done pulse; the post-release INIT RESET command resynchronises shadow with the register.

Verification
REQ-030 Reset release -> comand=001 for one cycle, then 000; busy high 1 cycle; shadow=0000; done never pulses.
REQ-031 LOAD data=1011 -> comand=010 one cycle with dataOut=1011; next cycle comand=000, done=1 one cycle; shadow=1011.
REQ-032 After LOAD 0011, SHL count=3 -> comand=011 for 3 cycles, busy high 3 cycles; then done; shadow 0110, 1100, 1000.
REQ-033 SHR count=0 -> no non-HOLD command, busy 1 cycle, then done; shadow unchanged.
REQ-034 start held high for 2 cycles during a 3-shift operation -> second request ignored; start in done cycle -> next command issued that cycle.
REQ-035 Reset asserted mid SHR count=5 -> outputs zeroed asynchronously, no done, INIT RESET issued after release; shadow matches a register model under negedge sampling throughout.
